// File: rtl/kiv_init_ctrl.sv
// -----------------------------------------------------------------------------
// kiv_init_ctrl -- key/IV load and warm-up sequencer for a chaotic-map
// keystream core.
//
// A key/IV load is started with `start`. The block then accepts six 32-bit
// key words (least-significant word first) and one IV word over a
// valid/ready handshake. Key words are collected in a shadow register, so the
// committed key seen by the core never changes mid-load. On the edge that
// accepts the IV word, the shadow key and the IV are committed to key_o/iv_o.
// The block then pulses load_o for one cycle and runs WARMUP_CYCLES discard
// iterations. After that it enters RUN, where ks_req drives the core step
// enable.
//
// Parameters
//   WARMUP_CYCLES  discard iterations after commit (0..1023); 0 skips WARMUP
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   begin key/IV load (honoured in IDLE and RUN only)
//   abort      in   return to IDLE from any state (highest priority)
//   din        in   [31:0] key/IV word
//   din_valid  in   din holds a valid word
//   din_ready  out  word accepted this cycle when din_valid is also high
//   ks_req     in   consumer requests keystream
//   key_o      out  [188:0] committed key
//   iv_o       out  [31:0]  committed IV
//   load_o     out  one-cycle pulse, core samples key_o/iv_o
//   warm_o     out  core iterates, output discarded
//   gen_en_o   out  core step enable for delivered keystream
//   busy_o     out  state is not IDLE
//
// Build option
//   KIV_ZEROIZE_EN  when defined, an abort outside IDLE also clears the
//                   shadow key, key_o and iv_o.
// -----------------------------------------------------------------------------
module kiv_init_ctrl #(
  parameter int unsigned WARMUP_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [31:0]  din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         ks_req,
  output logic [188:0] key_o,
  output logic [31:0]  iv_o,
  output logic         load_o,
  output logic         warm_o,
  output logic         gen_en_o,
  output logic         busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_IV,
    COMMIT,
    WARMUP,
    RUN
  } state_t;

  // Last value of the warm-up counter. When WARMUP_CYCLES is 0, WARMUP is
  // never entered and this value is unused.
  localparam logic [9:0] WARM_LAST =
    (WARMUP_CYCLES == 0) ? 10'd0 : 10'(WARMUP_CYCLES - 1);

  state_t       state;
  state_t       state_nxt;
  logic [2:0]   word_cnt;
  logic [9:0]   warm_cnt;
  logic [188:0] shadow;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a value before any branch;
    // otherwise synthesis infers a latch to hold it on the uncovered paths.
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) state_nxt = LOAD_KEY;
        LOAD_KEY: if (din_valid && word_cnt == 3'd5) state_nxt = LOAD_IV;
        LOAD_IV:  if (din_valid) state_nxt = COMMIT;
        COMMIT:   state_nxt = (WARMUP_CYCLES == 0) ? RUN : WARMUP;
        WARMUP:   if (warm_cnt == WARM_LAST) state_nxt = RUN;
        RUN:      if (start) state_nxt = LOAD_KEY;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from the state register. gen_en_o also follows ks_req
  // combinationally while in RUN. The three core strobes are exclusive
  // because each is tied to a different state.
  // ---------------------------------------------------------------------------
  assign din_ready = (state == LOAD_KEY) || (state == LOAD_IV);
  assign load_o    = (state == COMMIT);
  assign warm_o    = (state == WARMUP);
  assign gen_en_o  = (state == RUN) && ks_req;
  assign busy_o    = (state != IDLE);

  // ---------------------------------------------------------------------------
  // State, counters and key/IV datapath
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before this edge, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      word_cnt <= '0;
      warm_cnt <= '0;
      shadow   <= '0;
      key_o    <= '0;
      iv_o     <= '0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        // Abort outranks start and din acceptance, so the word presented in
        // this cycle is dropped.
        if (state != IDLE) begin
          word_cnt <= '0;
          warm_cnt <= '0;
`ifdef KIV_ZEROIZE_EN
          shadow   <= '0;
          key_o    <= '0;
          iv_o     <= '0;
`endif
        end
      end else begin
        case (state)
          LOAD_KEY: begin
            if (din_valid) begin
              case (word_cnt)
                3'd0:    shadow[31:0]    <= din;
                3'd1:    shadow[63:32]   <= din;
                3'd2:    shadow[95:64]   <= din;
                3'd3:    shadow[127:96]  <= din;
                3'd4:    shadow[159:128] <= din;
                // Top word only carries 29 key bits. din[31:29] is dropped.
                default: shadow[188:160] <= din[28:0];
              endcase
              word_cnt <= (word_cnt == 3'd5) ? 3'd0 : word_cnt + 3'd1;
            end
          end
          LOAD_IV: begin
            // The only commit point for key_o/iv_o outside reset/abort.
            if (din_valid) begin
              key_o <= shadow;
              iv_o  <= din;
            end
          end
          WARMUP: begin
            warm_cnt <= (warm_cnt == WARM_LAST) ? 10'd0 : warm_cnt + 10'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kiv_init_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kiv_init_ctrl -- self-checking bench for kiv_init_ctrl.
//
// Two instances share all inputs: one with WARMUP_CYCLES=4 and one with
// WARMUP_CYCLES=0. A reference model tracks each instance by word count and
// cycles since commit, and is compared against both instances every cycle.
// Directed table vectors and hand-written sequences cover the named
// scenarios. A randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_kiv_init_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] din;
  logic        din_valid;
  logic        ks_req;

  logic         rdy [2];
  logic         ld  [2];
  logic         wm  [2];
  logic         gen [2];
  logic         bsy [2];
  logic [188:0] key [2];
  logic [31:0]  iv  [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  kiv_init_ctrl #(.WARMUP_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .din(din),
    .din_valid(din_valid), .din_ready(rdy[0]), .ks_req(ks_req),
    .key_o(key[0]), .iv_o(iv[0]), .load_o(ld[0]), .warm_o(wm[0]),
    .gen_en_o(gen[0]), .busy_o(bsy[0])
  );

  kiv_init_ctrl #(.WARMUP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .din(din),
    .din_valid(din_valid), .din_ready(rdy[1]), .ks_req(ks_req),
    .key_o(key[1]), .iv_o(iv[1]), .load_o(ld[1]), .warm_o(wm[1]),
    .gen_en_o(gen[1]), .busy_o(bsy[1])
  );

  // ---------------------------------------------------------------------------
  // Reference model: m_words = -1 when idle, else the number of words taken
  // since start (7 = committed). m_since counts cycles since the IV word.
  // ---------------------------------------------------------------------------
  int           m_words [2];
  int           m_since [2];
  logic [31:0]  m_part  [2][6];
  logic [188:0] m_key   [2];
  logic [31:0]  m_iv    [2];

  function automatic int w_of(input int d);
    return (d == 0) ? 4 : 0;
  endfunction

  function automatic logic [188:0] pack_key(input logic [31:0] w0, w1, w2, w3, w4, w5);
    return {w5[28:0], w4, w3, w2, w1, w0};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_words[d] = -1;
      m_since[d] = 0;
      m_key[d]   = '0;
      m_iv[d]    = '0;
      for (int j = 0; j < 6; j++) m_part[d][j] = '0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (abort) begin
        if (m_words[d] >= 0) begin
          m_words[d] = -1;
`ifdef KIV_ZEROIZE_EN
          m_key[d] = '0;
          m_iv[d]  = '0;
          for (int j = 0; j < 6; j++) m_part[d][j] = '0;
`endif
        end
      end else if (m_words[d] < 0) begin
        if (start) m_words[d] = 0;
      end else if (m_words[d] < 7) begin
        if (din_valid) begin
          if (m_words[d] < 6) begin
            m_part[d][m_words[d]] = din;
          end else begin
            m_key[d] = pack_key(m_part[d][0], m_part[d][1], m_part[d][2],
                                m_part[d][3], m_part[d][4], m_part[d][5]);
            m_iv[d]    = din;
            m_since[d] = 0;
          end
          m_words[d]++;
        end
      end else begin
        if (start && m_since[d] > w_of(d)) m_words[d] = 0;
        else if (m_since[d] < 5000) m_since[d]++;
      end
    end
  endtask

  task automatic check(input string name, input logic [188:0] act, input logic [188:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic compare_model();
    for (int d = 0; d < 2; d++) begin
      logic committed, run_s;
      committed = (m_words[d] == 7);
      run_s     = committed && (m_since[d] > w_of(d));
      check($sformatf("busy[%0d]", d),  bsy[d], m_words[d] >= 0);
      check($sformatf("ready[%0d]", d), rdy[d], m_words[d] >= 0 && m_words[d] < 7);
      check($sformatf("load[%0d]", d),  ld[d],  committed && m_since[d] == 0);
      check($sformatf("warm[%0d]", d),  wm[d],  committed && m_since[d] >= 1 && m_since[d] <= w_of(d));
      check($sformatf("gen[%0d]", d),   gen[d], run_s && ks_req);
      check($sformatf("key[%0d]", d),   key[d], m_key[d]);
      check($sformatf("iv[%0d]", d),    iv[d],  m_iv[d]);
    end
  endtask

  // Inputs were driven at the preceding negedge; compare, take the edge,
  // advance the model, then return at the next negedge.
  task automatic cycle();
    #1 compare_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic s, a, v, input logic [31:0] d, input logic k);
    start = s; abort = a; din_valid = v; din = d; ks_req = k;
  endtask

  // ---------------------------------------------------------------------------
  // Directed table: normal load with WARMUP_CYCLES=4 (dut) and 0 (dut0)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        start, valid, ks;
    logic [31:0] din;
    logic        busy, ready, load, warm, gen;
    logic        load0, gen0;
  } vec_t;

  vec_t        tbl [15];
  logic [31:0] kw1 [6];
  logic [31:0] kw2 [6];
  localparam logic [31:0] IV1 = 32'hC33CB332;
  localparam logic [31:0] IV2 = 32'h5A5A0F0F;

  function automatic vec_t mk(input logic s, v, k, input logic [31:0] d,
                              input logic b, r, l, w, g, l0, g0);
    vec_t t;
    t.start = s; t.valid = v; t.ks = k; t.din = d;
    t.busy = b; t.ready = r; t.load = l; t.warm = w; t.gen = g;
    t.load0 = l0; t.gen0 = g0;
    return t;
  endfunction

  initial begin
    logic [188:0] k1, k2;
    int acc, cnt;

    kw1 = '{32'hA5A5A5A5, 32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h0BADF00D, 32'hFFFFFFFF};
    kw2 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555, 32'h06666666};
    k1  = {29'h1FFFFFFF, 32'h0BADF00D, 32'hDEADBEEF, 32'h89ABCDEF, 32'h01234567, 32'hA5A5A5A5};
    k2  = {29'h06666666, 32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    //             st v  ks din        bsy rdy ld wm gen ld0 gen0
    tbl[0]  = mk(1, 0, 0, 32'h0,      0,  0,  0, 0, 0,  0,  0);
    for (int i = 1; i <= 6; i++)
      tbl[i] = mk(0, 1, 0, kw1[i-1],  1,  1,  0, 0, 0,  0,  0);
    tbl[7]  = mk(0, 1, 0, IV1,        1,  1,  0, 0, 0,  0,  0);
    tbl[8]  = mk(0, 0, 0, 32'h0,      1,  0,  1, 0, 0,  1,  0);
    tbl[9]  = mk(0, 0, 1, 32'h0,      1,  0,  0, 1, 0,  0,  1);
    tbl[10] = mk(0, 0, 0, 32'h0,      1,  0,  0, 1, 0,  0,  0);
    tbl[11] = mk(0, 0, 0, 32'h0,      1,  0,  0, 1, 0,  0,  0);
    tbl[12] = mk(0, 0, 0, 32'h0,      1,  0,  0, 1, 0,  0,  0);
    tbl[13] = mk(0, 0, 1, 32'h0,      1,  0,  0, 0, 1,  0,  1);
    tbl[14] = mk(0, 0, 0, 32'h0,      1,  0,  0, 0, 0,  0,  0);

    // Reset
    drive(0, 0, 0, 32'h0, 0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1 compare_model();
    @(negedge clk);
    reset = 1'b0;

    // Normal load
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].start, 1'b0, tbl[i].valid, tbl[i].din, tbl[i].ks);
      #1;
      check($sformatf("tbl%0d.busy", i),  bsy[0], tbl[i].busy);
      check($sformatf("tbl%0d.ready", i), rdy[0], tbl[i].ready);
      check($sformatf("tbl%0d.load", i),  ld[0],  tbl[i].load);
      check($sformatf("tbl%0d.warm", i),  wm[0],  tbl[i].warm);
      check($sformatf("tbl%0d.gen", i),   gen[0], tbl[i].gen);
      check($sformatf("tbl%0d.load0", i), ld[1],  tbl[i].load0);
      check($sformatf("tbl%0d.gen0", i),  gen[1], tbl[i].gen0);
      cycle();
    end
    check("load_key", key[0], k1);
    check("load_iv", iv[0], {157'h0, IV1});
    check("load_key_w0", key[1], k1);

    // ks_req held for 10 cycles in RUN
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 32'h0, 1);
      #1 if (gen[0]) cnt++;
      cycle();
    end
    check("ks_run_10", cnt, 10);

    // Rekey from RUN: old key held, gen_en off until the new commit
    drive(1, 0, 0, 32'h0, 1);
    cycle();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, (i < 6) ? kw2[i] : IV2, 1);
      #1;
      check("rekey_gen_off", gen[0], 1'b0);
      check("rekey_key_held", key[0], k1);
      cycle();
    end
    check("rekey_new_key", key[0], k2);
    check("rekey_new_iv", iv[0], {157'h0, IV2});
    drive(0, 0, 0, 32'h0, 0);
    repeat (5) cycle();

    // Backpressure: din_valid toggles every cycle
    drive(1, 0, 0, 32'h0, 0);
    cycle();
    acc = 0;
    for (int k = 0; k < 30 && acc < 7; k++) begin
      drive(0, 0, (k % 2) == 0, (acc < 6) ? kw1[acc] : IV1, 0);
      #1 if (rdy[0] && din_valid) acc++;
      cycle();
    end
    check("bp_words", acc, 7);
    check("bp_key", key[0], k1);
    drive(0, 0, 0, 32'h0, 0);
    repeat (5) cycle();

    // Abort after word 3, with a valid word in the abort cycle
    drive(1, 0, 0, 32'h0, 0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, kw2[i], 0);
      cycle();
    end
    drive(0, 1, 1, kw2[4], 0);
    cycle();
    drive(0, 0, 0, 32'h0, 0);
    #1;
    check("abort_busy", bsy[0], 1'b0);
`ifdef KIV_ZEROIZE_EN
    check("abort_key", key[0], '0);
`else
    check("abort_key", key[0], k1);
`endif
    cycle();
    // Abort in IDLE, and start+abort together: both stay in IDLE
    drive(0, 1, 0, 32'h0, 0);
    cycle();
    drive(1, 1, 0, 32'h0, 0);
    cycle();
    drive(0, 0, 0, 32'h0, 0);
    cycle();

    // Asynchronous reset in the middle of WARMUP
    drive(1, 0, 0, 32'h0, 1);
    cycle();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, (i < 6) ? kw2[i] : IV2, 1);
      cycle();
    end
    drive(0, 0, 0, 32'h0, 1);
    repeat (3) cycle();
    check("pre_reset_warm", wm[0], 1'b1);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("arst_busy[%0d]", d), bsy[d], 1'b0);
      check($sformatf("arst_ready[%0d]", d), rdy[d], 1'b0);
      check($sformatf("arst_load[%0d]", d), ld[d], 1'b0);
      check($sformatf("arst_warm[%0d]", d), wm[d], 1'b0);
      check($sformatf("arst_gen[%0d]", d), gen[d], 1'b0);
      check($sformatf("arst_key[%0d]", d), key[d], '0);
      check($sformatf("arst_iv[%0d]", d), iv[d], '0);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      drive($urandom_range(99) < 10, $urandom_range(99) < 3,
            $urandom_range(99) < 60, $urandom, $urandom_range(1));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
